sdram_sched_3p: RTL and testbench
=================================

Name: sdram_sched_3p

Overview:
Three-port scheduler that shares the single SDRAM controller command port between the video fetcher, the CPU memory controller and a DMA engine.
- Video has fixed priority and issues burst reads.
- CPU and DMA are served round-robin.
- A starvation counter forces a CPU/DMA slot after too many consecutive video grants.
- Sits between the per-requester SDRAM buses and the SDRAM controller's sys_* port. It replaces the two-port arbiter in the top level.

Parameters:
ADDR_W, 24, SDRAM word address width (16-bit words)
DATA_W, 16, data width
BURST_LEN, 4, read words returned per video burst (power of 2, 2..8)
STARVE_LIMIT, 4, consecutive video grants allowed while CPU/DMA waits (1..15)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
vid_rd  in  1  video burst read request, level, held until vid_ack
vid_addr  in  ADDR_W  video burst start address
vid_ack  out  1  1-cycle command-accepted pulse
vid_rdy  out  1  video read word valid
cpu_rd / cpu_wr  in  1  CPU read / write request, level, held until cpu_ack
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_wmask  in  2  CPU byte enables
cpu_ack  out  1  1-cycle accept pulse
cpu_rdy  out  1  CPU read word valid
dma_rd / dma_wr / dma_addr / dma_wdata / dma_wmask / dma_ack / dma_rdy  same as cpu_*
rdata_o  out  DATA_W  read data, broadcast to all requesters; qualified by the per-port *_rdy
ctrl_rd / ctrl_wr  out  1  command to SDRAM controller, held until ctrl_ack
ctrl_addr  out  ADDR_W  registered command address
ctrl_wdata  out  DATA_W  registered write data
ctrl_wmask  out  2  registered byte enables
ctrl_burst  out  1  1 = burst read of BURST_LEN words
ctrl_ack  in  1  controller accepted command (1-cycle pulse)
ctrl_rdy  in  1  controller read word valid
ctrl_rdata  in  DATA_W  controller read data
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE.
  - ctrl_rd, ctrl_wr, ctrl_burst, all *_ack, all *_rdy and busy_o = 0.
  - ctrl_addr, ctrl_wdata, ctrl_wmask = 0.
  - rr_last = DMA, so the CPU wins the first tie.
  - starve_cnt = 0.
  - Reset mid-transaction abandons the transaction; the SDRAM controller shares the same reset.
- Requests: a port's request is valid when rd or wr is high. If a port asserts rd and wr together, wr wins; exactly one ack is given.
- States:
  - IDLE:
    - If no request, stay in IDLE.
    - Otherwise select the winner:
      - video, if vid_rd and not (starve_cnt == STARVE_LIMIT and a CPU/DMA request is pending);
      - else CPU/DMA round-robin: the port not equal to rr_last wins when both request.
    - Latch the winner's addr/wdata/wmask/op into the ctrl_* registers; set ctrl_burst = (winner == video).
    - Go to CMD. ctrl_rd/ctrl_wr assert the following cycle, i.e. 1 cycle after the request is sampled.
  - CMD:
    - Hold ctrl_* stable until ctrl_ack.
    - On ctrl_ack, pulse the winner's *_ack combinationally in the same cycle, deassert ctrl_rd/ctrl_wr next cycle, and update counters (see Starvation).
    - Next state: read → RDATA with word count = BURST_LEN for video, 1 otherwise; write → IDLE.
  - RDATA:
    - Each ctrl_rdy cycle drives the winner's *_rdy = 1 combinationally, with rdata_o = ctrl_rdata.
    - Decrement the word count; on the last word go to IDLE, so a new arbitration happens the next cycle.
    - ctrl_rdy while in IDLE/CMD is ignored; no *_rdy pulse.
- Starvation:
  - On a video ctrl_ack: starve_cnt increments if a CPU/DMA request is pending, saturating at STARVE_LIMIT.
  - On a CPU/DMA ctrl_ack: starve_cnt clears and rr_last is set to the granted port.
- Minimum turnaround is IDLE→CMD→(ack)→IDLE, i.e. 3 cycles for writes with an immediate ack.
- Requester obligations: hold the request and its payload until *_ack, and drop it in the cycle after *_ack. A request still high in that cycle is treated as a new request.
- Never more than one command outstanding; no *_rdy is ever routed to a non-winning port.

Test Plan:
1. CPU write only: cpu_wr=1, addr=0x000100, wdata=0xBEEF, wmask=2'b11, ctrl_ack 2 cycles after ctrl_wr → ctrl_wr high with matching payload; cpu_ack one pulse coincident with ctrl_ack; busy_o back to 0; no cpu_rdy.
2. Video burst: vid_rd at addr 0x010000, controller returns 4 words 0x1111..0x4444 → ctrl_burst=1; exactly 4 vid_rdy pulses with rdata_o matching in order; zero cpu_rdy/dma_rdy.
3. Round-robin: CPU and DMA reads both held continuously for 4 grants → grant order CPU, DMA, CPU, DMA; each port receives exactly 1 rdy per grant.
4. Starvation: vid_rd held permanently plus cpu_rd pending, STARVE_LIMIT=4 → 4 video bursts, then a CPU grant, then video resumes; starve_cnt observed cleared.
5. Simultaneous rd+wr on DMA → single write to controller, one dma_ack, no dma_rdy.
6. Reset asserted mid-RDATA (after 2 of 4 words) → all outputs 0 asynchronously; after release, a CPU read completes normally with CPU winning over a simultaneous DMA read.

Source files
------------

// File: rtl/sdram_sched_3p.sv
// Three-port SDRAM command scheduler: video has fixed priority and issues burst reads;
// CPU and DMA share the remaining slots round-robin, with a starvation guard against video.
module sdram_sched_3p #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vid_rd,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rdy,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_wmask,
    output logic              cpu_ack,
    output logic              cpu_rdy,
    input  logic              dma_rd,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [1:0]        dma_wmask,
    output logic              dma_ack,
    output logic              dma_rdy,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ctrl_rd,
    output logic              ctrl_wr,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic [1:0]        ctrl_wmask,
    output logic              ctrl_burst,
    input  logic              ctrl_ack,
    input  logic              ctrl_rdy,
    input  logic [DATA_W-1:0] ctrl_rdata,
    output logic              busy_o
);
    localparam logic [3:0] BURST_CNT  = 4'(BURST_LEN);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_RDATA = 2'd2} state_t;
    typedef enum logic [1:0] {P_VID = 2'd0, P_CPU = 2'd1, P_DMA = 2'd2} port_t;

    state_t            state_r;
    state_t            state_nxt_s;
    port_t             win_r;
    port_t             win_s;
    port_t             rr_last_r;
    logic [3:0]        word_cnt_r;
    logic [3:0]        starve_cnt_r;
    logic              cpu_req_s;
    logic              dma_req_s;
    logic              cd_pend_s;
    logic              req_any_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [1:0]        sel_wmask_s;
    logic              sel_wr_s;
    logic              ack_s;
    logic              rdy_s;

    // Winner selection: video first unless CPU/DMA has waited out the starvation budget.
    always_comb begin
        cpu_req_s = cpu_rd | cpu_wr;
        dma_req_s = dma_rd | dma_wr;
        cd_pend_s = cpu_req_s | dma_req_s;
        req_any_s = vid_rd | cd_pend_s;
        win_s     = P_VID;
        if (vid_rd && !((starve_cnt_r == STARVE_MAX) && cd_pend_s)) begin
            win_s = P_VID;
        end else if (cpu_req_s && dma_req_s) begin
            win_s = (rr_last_r == P_DMA) ? P_CPU : P_DMA;
        end else if (cpu_req_s) begin
            win_s = P_CPU;
        end else if (dma_req_s) begin
            win_s = P_DMA;
        end else begin
            win_s = P_VID;
        end
    end

    // Payload of the selected port; write wins over read on a port asserting both.
    always_comb begin
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        sel_wmask_s = 2'b00;
        sel_wr_s    = 1'b0;
        case (win_s)
            P_VID: begin
                sel_addr_s = vid_addr;
            end
            P_CPU: begin
                sel_addr_s  = cpu_addr;
                sel_wdata_s = cpu_wdata;
                sel_wmask_s = cpu_wmask;
                sel_wr_s    = cpu_wr;
            end
            P_DMA: begin
                sel_addr_s  = dma_addr;
                sel_wdata_s = dma_wdata;
                sel_wmask_s = dma_wmask;
                sel_wr_s    = dma_wr;
            end
            default: begin
                sel_wr_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) state_nxt_s = ST_CMD;
                else           state_nxt_s = ST_IDLE;
            end
            ST_CMD: begin
                if (ctrl_ack) state_nxt_s = ctrl_wr ? ST_IDLE : ST_RDATA;
                else          state_nxt_s = ST_CMD;
            end
            ST_RDATA: begin
                if (ctrl_rdy && (word_cnt_r == 4'd1)) state_nxt_s = ST_IDLE;
                else                                  state_nxt_s = ST_RDATA;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Acks and read valids go only to the current winner, and only in the matching state.
    always_comb begin
        ack_s   = (state_r == ST_CMD) && ctrl_ack;
        rdy_s   = (state_r == ST_RDATA) && ctrl_rdy;
        vid_ack = ack_s && (win_r == P_VID);
        cpu_ack = ack_s && (win_r == P_CPU);
        dma_ack = ack_s && (win_r == P_DMA);
        vid_rdy = rdy_s && (win_r == P_VID);
        cpu_rdy = rdy_s && (win_r == P_CPU);
        dma_rdy = rdy_s && (win_r == P_DMA);
        rdata_o = rdy_s ? ctrl_rdata : {DATA_W{1'b0}};
        busy_o  = (state_r != ST_IDLE);
    end

    // Command registers, word counter, starvation counter and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_r        <= P_VID;
            rr_last_r    <= P_DMA;
            word_cnt_r   <= 4'd0;
            starve_cnt_r <= 4'd0;
            ctrl_rd      <= 1'b0;
            ctrl_wr      <= 1'b0;
            ctrl_burst   <= 1'b0;
            ctrl_addr    <= {ADDR_W{1'b0}};
            ctrl_wdata   <= {DATA_W{1'b0}};
            ctrl_wmask   <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        win_r      <= win_s;
                        ctrl_addr  <= sel_addr_s;
                        ctrl_wdata <= sel_wdata_s;
                        ctrl_wmask <= sel_wmask_s;
                        ctrl_rd    <= !sel_wr_s;
                        ctrl_wr    <= sel_wr_s;
                        ctrl_burst <= (win_s == P_VID);
                    end
                end
                ST_CMD: begin
                    if (ctrl_ack) begin
                        ctrl_rd    <= 1'b0;
                        ctrl_wr    <= 1'b0;
                        ctrl_burst <= 1'b0;
                        word_cnt_r <= (win_r == P_VID) ? BURST_CNT : 4'd1;
                        if (win_r == P_VID) begin
                            if (cd_pend_s && (starve_cnt_r != STARVE_MAX)) begin
                                starve_cnt_r <= starve_cnt_r + 4'd1;
                            end
                        end else begin
                            starve_cnt_r <= 4'd0;
                            rr_last_r    <= win_r;
                        end
                    end
                end
                ST_RDATA: begin
                    if (ctrl_rdy) word_cnt_r <= word_cnt_r - 4'd1;
                end
                default: begin
                    ctrl_rd <= 1'b0;
                    ctrl_wr <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_sched_3p.sv
// Bench for sdram_sched_3p: directed scenarios plus a randomized phase, with the bench acting
// as the SDRAM controller and checking grants against a transaction-level arbitration model.
module tb_sdram_sched_3p;
    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        vid_rd;
    logic [23:0] vid_addr;
    logic        vid_ack, vid_rdy;
    logic        cpu_rd, cpu_wr;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_wmask;
    logic        cpu_ack, cpu_rdy;
    logic        dma_rd, dma_wr;
    logic [23:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [1:0]  dma_wmask;
    logic        dma_ack, dma_rdy;
    logic [15:0] rdata_o;
    logic        ctrl_rd, ctrl_wr;
    logic [23:0] ctrl_addr;
    logic [15:0] ctrl_wdata;
    logic [1:0]  ctrl_wmask;
    logic        ctrl_burst;
    logic        ctrl_ack, ctrl_rdy;
    logic [15:0] ctrl_rdata;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    // Reference model: pending requests, their payloads, starvation count and last CPU/DMA grant.
    bit          pend   [3];
    logic [23:0] e_addr [3];
    logic [15:0] e_wdata[3];
    logic [1:0]  e_wmask[3];
    bit          e_wr   [3];
    int          starve_m;
    int          rr_m;
    int          rr3  [4]  = '{1, 2, 1, 2};
    int          seq4 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int          w;

    sdram_sched_3p #(.ADDR_W(24), .DATA_W(16), .BURST_LEN(4), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdy(vid_rdy),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack), .cpu_rdy(cpu_rdy),
        .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_wmask(dma_wmask), .dma_ack(dma_ack), .dma_rdy(dma_rdy),
        .rdata_o(rdata_o),
        .ctrl_rd(ctrl_rd), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_wmask(ctrl_wmask), .ctrl_burst(ctrl_burst), .ctrl_ack(ctrl_ack),
        .ctrl_rdy(ctrl_rdy), .ctrl_rdata(ctrl_rdata), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {22'd0, ctrl_rd, ctrl_wr, ctrl_burst, vid_ack, vid_rdy, cpu_ack,
                              cpu_rdy, dma_ack, dma_rdy, busy_o}, 32'd0);
        chk({tag, "_addr"},  {8'd0, ctrl_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, ctrl_wdata}, 32'd0);
        chk({tag, "_wmask"}, {30'd0, ctrl_wmask}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, rdata_o}, 32'd0);
    endtask

    task automatic raise(input int p, input bit rd, input bit wr, input logic [23:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        pend[p]    = 1'b1;
        e_addr[p]  = a;
        e_wdata[p] = d;
        e_wmask[p] = m;
        e_wr[p]    = wr && (p != 0);
        case (p)
            0:       begin vid_rd = 1'b1; vid_addr = a; end
            1:       begin cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_wmask = m; end
            default: begin dma_rd = rd; dma_wr = wr; dma_addr = a; dma_wdata = d; dma_wmask = m; end
        endcase
    endtask

    task automatic raise_rand(input int p);
        int op;
        op = $urandom_range(0, 2);
        raise(p, op != 1, op != 0, 24'($urandom), 16'($urandom), 2'($urandom));
    endtask

    task automatic drop(input int p);
        pend[p] = 1'b0;
        case (p)
            0:       vid_rd = 1'b0;
            1:       begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
            default: begin dma_rd = 1'b0; dma_wr = 1'b0; end
        endcase
    endtask

    function automatic int exp_winner();
        if (pend[0] && !(starve_m == LIMIT && (pend[1] || pend[2]))) return 0;
        if (pend[1] && pend[2]) return (rr_m == 2) ? 1 : 2;
        if (pend[1]) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 3; p++) drop(p);
        starve_m = 0;
        rr_m     = 2;
    endtask

    task automatic do_reset();
        model_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    // One full transaction as seen by the controller side; stop_after>0 abandons a read early.
    task automatic do_xact(input int ack_dly, input int stop_after, input bit seq_data,
                           output int win);
        int n, wp, words;
        bit wr;
        logic [2:0]  onehot;
        logic [15:0] d;
        win = -1;
        n   = 0;
        while (!(ctrl_rd || ctrl_wr) && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_latency", n, 1);
        if (!(ctrl_rd || ctrl_wr)) return;
        wp     = exp_winner();
        win    = wp;
        wr     = e_wr[wp];
        onehot = 3'b001 << wp;
        chk("cmd_op", {30'd0, ctrl_rd, ctrl_wr}, {30'd0, !wr, wr});
        chk("cmd_addr", {8'd0, ctrl_addr}, {8'd0, e_addr[wp]});
        chk("cmd_burst", ctrl_burst, wp == 0);
        chk("busy_cmd", busy_o, 1);
        if (wr) begin
            chk("cmd_wdata", ctrl_wdata, e_wdata[wp]);
            chk("cmd_wmask", ctrl_wmask, e_wmask[wp]);
        end
        for (int i = 0; i < ack_dly; i++) begin
            ctrl_rdy   = 1'($urandom_range(0, 1));
            ctrl_rdata = 16'($urandom);
            #1;
            chk("stray_rdy_cmd", {dma_rdy, cpu_rdy, vid_rdy}, 0);
            chk("early_ack", {dma_ack, cpu_ack, vid_ack}, 0);
            chk("cmd_hold", {8'd0, ctrl_addr}, {8'd0, e_addr[wp]});
            tick();
        end
        ctrl_rdy = 1'b0;
        ctrl_ack = 1'b1;
        #1;
        chk("ack_route", {dma_ack, cpu_ack, vid_ack}, onehot);
        if (wp == 0) begin
            if ((pend[1] || pend[2]) && starve_m < LIMIT) starve_m++;
        end else begin
            starve_m = 0;
            rr_m     = wp;
        end
        tick();
        ctrl_ack = 1'b0;
        drop(wp);
        chk("cmd_released", {ctrl_rd, ctrl_wr}, 0);
        chk("ack_single", {dma_ack, cpu_ack, vid_ack}, 0);
        if (!wr) begin
            words = (wp == 0) ? 4 : 1;
            for (int k = 0; k < words; k++) begin
                if (stop_after > 0 && k == stop_after) return;
                repeat ($urandom_range(0, 2)) begin
                    ctrl_rdy = 1'b0;
                    #1;
                    chk("gap_rdy", {dma_rdy, cpu_rdy, vid_rdy}, 0);
                    tick();
                end
                d          = seq_data ? 16'(16'h1111 * (k + 1)) : 16'($urandom);
                ctrl_rdy   = 1'b1;
                ctrl_rdata = d;
                #1;
                chk("rdy_route", {dma_rdy, cpu_rdy, vid_rdy}, onehot);
                chk("rdata", rdata_o, d);
                tick();
                ctrl_rdy = 1'b0;
            end
        end
        chk("idle_after", busy_o, 0);
    endtask

    initial begin
        rst_ni   = 1'b0;
        ctrl_ack = 1'b0; ctrl_rdy = 1'b0; ctrl_rdata = 16'h0;
        vid_addr = 24'h0; cpu_addr = 24'h0; dma_addr = 24'h0;
        cpu_wdata = 16'h0; dma_wdata = 16'h0; cpu_wmask = 2'b00; dma_wmask = 2'b00;
        model_reset();
        tick();
        tick();
        chk_all_zero("reset");
        rst_ni = 1'b1;

        // CPU write with a two-cycle controller ack
        raise(1, 1'b0, 1'b1, 24'h000100, 16'hBEEF, 2'b11);
        do_xact(2, 0, 1'b1, w);
        chk("t1_winner", w, 1);

        // Video burst with known data pattern
        raise(0, 1'b1, 1'b0, 24'h010000, 16'h0, 2'b00);
        do_xact(1, 0, 1'b1, w);
        chk("t2_winner", w, 0);

        // Round-robin between continuously requesting CPU and DMA
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (!pend[1]) raise(1, 1'b1, 1'b0, 24'($urandom), 16'h0, 2'b00);
            if (!pend[2]) raise(2, 1'b1, 1'b0, 24'($urandom), 16'h0, 2'b00);
            do_xact($urandom_range(0, 2), 0, 1'b0, w);
            chk("t3_rr_order", w, rr3[i]);
        end

        // Starvation: video held permanently, CPU re-requests after each grant
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (!pend[0]) raise(0, 1'b1, 1'b0, 24'($urandom), 16'h0, 2'b00);
            if (!pend[1]) raise(1, 1'b1, 1'b0, 24'($urandom), 16'h0, 2'b00);
            do_xact(0, 0, 1'b0, w);
            chk("t4_starve_order", w, seq4[i]);
        end

        // DMA rd+wr together: a single write, no read data
        do_reset();
        raise(2, 1'b1, 1'b1, 24'h00ABCD, 16'h1234, 2'b01);
        do_xact(0, 0, 1'b0, w);
        chk("t5_winner", w, 2);
        ctrl_rdy   = 1'b1;
        ctrl_rdata = 16'h5A5A;
        #1;
        chk("t5_idle_rdy", {dma_rdy, cpu_rdy, vid_rdy}, 0);
        tick();
        ctrl_rdy = 1'b0;

        // Reset in the middle of a video burst, then a CPU/DMA tie
        do_reset();
        raise(0, 1'b1, 1'b0, 24'h020000, 16'h0, 2'b00);
        do_xact(0, 2, 1'b1, w);
        ctrl_rdy   = 1'b1;
        ctrl_rdata = 16'h3333;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("t6_midreset");
        model_reset();
        ctrl_rdy = 1'b0;
        tick();
        rst_ni = 1'b1;
        raise(1, 1'b1, 1'b0, 24'h000200, 16'h0, 2'b00);
        raise(2, 1'b1, 1'b0, 24'h000300, 16'h0, 2'b00);
        do_xact(1, 0, 1'b0, w);
        chk("t6_cpu_first", w, 1);
        do_xact(0, 0, 1'b0, w);
        chk("t6_dma_next", w, 2);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 3; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) raise_rand(p);
            end
            if (!pend[0] && !pend[1] && !pend[2]) raise_rand($urandom_range(0, 2));
            do_xact($urandom_range(0, 3), 0, 1'b0, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
